// File: rtl/pc_stack_seq_if.sv
// Decoder-to-sequencer bundle: control strobes and targets in, PC and stack status out.
// The master is the decoder side; the slave is the sequencer.
interface pc_stack_seq_if #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned STACK_DEPTH = 4
) ();
  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

  logic              en;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_adrs;
  logic              br;
  logic [ADDR_W-1:0] br_off;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pcout;
  logic [DepthW-1:0] depth;
  logic              stack_full;
  logic              stack_empty;
  logic              ovf;
  logic              unf;

  modport master (
    output en, jmp, jmp_adrs, br, br_off, call, ret,
    input  pcout, depth, stack_full, stack_empty, ovf, unf
  );

  modport slave (
    input  en, jmp, jmp_adrs, br, br_off, call, ret,
    output pcout, depth, stack_full, stack_empty, ovf, unf
  );
endinterface

// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with increment, jump, relative branch and a call/return stack.
// Priority when enabled: ret > call > jmp > br > increment; all outputs are registered.
module pc_stack_seq #(
  parameter int unsigned       ADDR_W      = 6,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input logic           clk_i,
  input logic           rst_ni,
  pc_stack_seq_if.slave bus
);
  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic              full, empty, push;
  logic [IdxW-1:0]   top_idx, push_idx;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign full     = (depth_q == DepthW'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  // Only read when non-empty and only written when not full, so truncation is safe.
  assign top_idx  = IdxW'(depth_q - DepthW'(1));
  assign push_idx = IdxW'(depth_q);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (bus.en) begin
      if (bus.ret) begin
        if (!empty) begin
          pc_d    = stack_q[top_idx];
          depth_d = depth_q - DepthW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.call) begin
        pc_d = bus.jmp_adrs;
        if (!full) begin
          push    = 1'b1;
          depth_d = depth_q + DepthW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.jmp) begin
        pc_d = bus.jmp_adrs;
      end else if (bus.br) begin
        // Same-width modulo add is identical to adding the sign-extended offset.
        pc_d = pc_q + bus.br_off;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.pcout       = pc_q;
  assign bus.depth       = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq (ADDR_W=6, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_stack_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  pc_stack_seq_if #(.ADDR_W(6), .STACK_DEPTH(4)) bus ();

  pc_stack_seq #(
    .ADDR_W     (6),
    .STACK_DEPTH(4),
    .RESET_VEC  (6'd0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed state packed as {pcout, depth, full, empty, ovf, unf}.
  function automatic logic [12:0] snap();
    return {bus.pcout, bus.depth, bus.stack_full, bus.stack_empty, bus.ovf, bus.unf};
  endfunction

  function automatic logic [12:0] want(input int pc, input int d, input bit o, input bit u);
    logic [5:0] p6;
    logic [2:0] d3;
    p6 = 6'(pc);
    d3 = 3'(d);
    return {p6, d3, (d == 4), (d == 0), o, u};
  endfunction

  task automatic drive(input bit en, input bit jmp, input bit call, input bit ret, input bit br,
                       input int adrs, input int off);
    bus.en       = en;
    bus.jmp      = jmp;
    bus.call     = call;
    bus.ret      = ret;
    bus.br       = br;
    bus.jmp_adrs = 6'(adrs);
    bus.br_off   = 6'(off);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    exp = want(0, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL reset_async: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (snap() !== exp) $display("FAIL reset_held_edge: got %h want %h", snap(), exp);
    else passed++;
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = want(i, 0, 0, 0);
      checks++;
      if (snap() !== exp) $display("FAIL incr_%0d: got %h want %h", i, snap(), exp);
      else passed++;
    end
    drive(1, 1, 0, 0, 0, 63, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    exp = want(0, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL incr_wrap: got %h want %h", snap(), exp);
    else passed++;
  endtask

  task automatic test_stall_jump_branch();
    logic [12:0] exp;
    drive(0, 1, 0, 0, 0, 40, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = want(0, 0, 0, 0);
      checks++;
      if (snap() !== exp) $display("FAIL stall_%0d: got %h want %h", i, snap(), exp);
      else passed++;
    end
    drive(1, 1, 0, 0, 0, 40, 0);
    tick();
    exp = want(40, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL jmp40: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 1, 0, 'h3E);
    tick();
    exp = want(38, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL br_minus2: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 1, 0, 5);
    tick();
    exp = want(43, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL br_plus5: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 1, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 'h3E);
    tick();
    exp = want(63, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL br_wrap_low: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 1, 0, 1);
    tick();
    exp = want(0, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL br_wrap_high: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_nested_call();
    int          pcs [5] = '{10, 20, 30, 21, 11};
    int          dps [5] = '{0, 1, 2, 1, 0};
    logic [12:0] exp;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1, 1, 0, 0, 0, 10, 0);
        1:       drive(1, 0, 1, 0, 0, 20, 0);
        2:       drive(1, 0, 1, 0, 0, 30, 0);
        default: drive(1, 0, 0, 1, 0, 0, 0);
      endcase
      tick();
      exp = want(pcs[i], dps[i], 0, 0);
      checks++;
      if (snap() !== exp) $display("FAIL nested_%0d: got %h want %h", i, snap(), exp);
      else passed++;
    end
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_ovf_unf();
    int          pcs [10] = '{50, 51, 52, 53, 54, 53, 52, 51, 12, 13};
    int          dps [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
    bit          ovs [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit          uns [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [12:0] exp;
    // Starts at pc=11 with an empty stack.
    for (int i = 0; i < 10; i++) begin
      if (i < 5) drive(1, 0, 1, 0, 0, 50 + i, 0);
      else       drive(1, 0, 0, 1, 0, 0, 0);
      tick();
      exp = want(pcs[i], dps[i], ovs[i], uns[i]);
      checks++;
      if (snap() !== exp) $display("FAIL ovfunf_%0d: got %h want %h", i, snap(), exp);
      else passed++;
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    exp = want(14, 0, 1, 1);
    checks++;
    if (snap() !== exp) $display("FAIL sticky_incr: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 1, 0, 0, 0, 9, 0);
    tick();
    exp = want(9, 0, 1, 1);
    checks++;
    if (snap() !== exp) $display("FAIL sticky_jmp: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_priority();
    int          pcs [11] = '{11, 40, 12, 13, 3, 7, 4, 63, 5, 0, 0};
    int          dps [11] = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    logic [12:0] exp;
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:  drive(1, 1, 0, 0, 0, 11, 0);
        1:  drive(1, 0, 1, 0, 0, 40, 0);
        2:  drive(1, 1, 1, 1, 0, 25, 0);
        3:  drive(1, 0, 0, 0, 0, 0, 0);
        4:  drive(1, 1, 0, 0, 0, 3, 0);
        5:  drive(1, 1, 1, 0, 1, 7, 1);
        6:  drive(1, 0, 0, 1, 0, 0, 0);
        7:  drive(1, 1, 0, 0, 0, 63, 0);
        8:  drive(1, 0, 1, 0, 0, 5, 0);
        9:  drive(1, 0, 0, 1, 0, 0, 0);
        default: drive(0, 0, 1, 1, 0, 9, 0);
      endcase
      tick();
      exp = want(pcs[i], dps[i], 1, 1);
      checks++;
      if (snap() !== exp) $display("FAIL prio_%0d: got %h want %h", i, snap(), exp);
      else passed++;
    end
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    logic [12:0] exp;
    drive(1, 0, 1, 0, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0, 2, 0);
    tick();
    drive(1, 0, 1, 0, 0, 50, 0);
    tick();
    exp = want(50, 3, 1, 1);
    checks++;
    if (snap() !== exp) $display("FAIL pre_reset: got %h want %h", snap(), exp);
    else passed++;
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    exp = want(0, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL mid_reset: got %h want %h", snap(), exp);
    else passed++;
    #1 rst_n = 1'b1;
    tick();
    exp = want(1, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL post_reset_1: got %h want %h", snap(), exp);
    else passed++;
    tick();
    exp = want(2, 0, 0, 0);
    checks++;
    if (snap() !== exp) $display("FAIL post_reset_2: got %h want %h", snap(), exp);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_stall_jump_branch();
    test_nested_call();
    test_ovf_unf();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pc_stack_seq.md
Name: pc_stack_seq

Overview:
Parametrised program-counter sequencer; the next generation of the 6-bit increment/jump PC. It adds relative branches, a stall enable, and a hardware call/return stack, with configurable address width and stack depth. It sits between the instruction decoder (jmp/br/call/ret strobes) and instruction memory (pcout).

Parameters:
ADDR_W, 6, PC and address width in bits (>=2)
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  advance enable; 0 = stall (PC, stack and flags hold)
jmp  input  1  absolute jump to jmp_adrs
jmp_adrs  input  ADDR_W  absolute target; also the call target
br  input  1  relative branch
br_off  input  ADDR_W  signed two's-complement branch offset, relative to current PC
call  input  1  push PC+1, go to jmp_adrs
ret  input  1  pop return address into PC
pcout  output  ADDR_W  current PC
depth  output  clog2(STACK_DEPTH+1)  occupied stack entries
stack_full  output  1  depth == STACK_DEPTH
stack_empty  output  1  depth == 0
ovf  output  1  sticky: call attempted while full
unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (rst low, async, no clock needed): pcout=RESET_VEC, depth=0, stack_empty=1, stack_full=0, ovf=0, unf=0. Stack contents don't-care. Reset mid-call/ret aborts it; the first edge after rst rises acts normally.
- All updates occur on rising clk with en=1. With en=0, all state holds and the strobes are ignored.
- Next-PC priority, highest first, when en=1:
  ret > call > jmp > br > increment.
  - ret, depth>0: PC <= stack[top]; depth-1.
  - ret, depth==0: PC <= PC+1; depth unchanged; unf <= 1.
  - call, depth<STACK_DEPTH: stack[depth] <= PC+1; depth+1; PC <= jmp_adrs.
  - call, full: PC <= jmp_adrs (jump still taken); stack unchanged; ovf <= 1.
  - jmp: PC <= jmp_adrs.
  - br: PC <= PC + sign-extended br_off.
  - none: PC <= PC+1.
- Arithmetic is modulo 2^ADDR_W. PC+1 from all-ones wraps to 0. A branch past either end wraps; no flag is raised.
- Lower-priority strobes asserted in the same cycle as a winner are ignored entirely; e.g. call+ret gives a pop only, with no push.
- The pushed return address is PC+1 with wrap, so a call at all-ones pushes 0.
- Latency: one cycle. pcout reflects the decision made on the previous edge. pcout and flags are registered outputs, with no combinational input-to-output path.
- depth, stack_full and stack_empty are derived from the registered depth. ovf and unf clear only on reset.
- Stack is LIFO. The top entry is stack[depth-1]; entries above depth are don't-care.

Test Plan:
- Reset/increment: hold rst low, release; en=1, no strobes, 5 edges -> pcout 0,1,2,3,4,5; stack_empty=1. From pcout=63, one edge -> 0.
- Stall/jump/branch: en=0 for 3 edges -> pcout holds. jmp, jmp_adrs=40 -> 40. Then br, br_off=6'h3E (-2) -> 38. Then br, br_off=5 -> 43.
- Nested call/return: at pc=10, call to 20; at 20, call to 30 -> depth=2. ret -> 21, ret -> 11, depth=0, stack_empty=1.
- Overflow/underflow: 5 successive calls (DEPTH=4) -> depth=4, stack_full=1, ovf=1, PC at 5th target; 4 rets unwind correctly. 5th ret -> pcout=prev+1, unf=1, depth=0. Both flags persist until rst.
- Priority/collision: ret+call+jmp in one cycle with depth=1, top=12 -> pcout=12, depth=0, no push. call+jmp+br with jmp_adrs=7 at pc=3 -> pcout=7, pushed 4.
- Async reset mid-operation: assert rst low between edges with depth=3, pcout=50 -> immediately pcout=0, depth=0, flags 0. After release, next edge -> 1.
